// File: rtl/player_input.sv
// Debounced switch/start front end for the LED game: synchronise, debounce, and
// turn each press into a single one-hot move offered over a valid/ready handshake.
//
// state   | meaning
// INIT    | waiting for the first debounced commit after reset
// ARMED   | all switches off, waiting for a press
// OFFER   | one-hot move offered, waiting for move_ready
// RELEASE | waiting for every switch to return to 0
module player_input #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             start_raw,
  output logic [WIDTH-1:0] switch_out,
  output logic             parity,
  output logic             start_pulse,
  output logic [WIDTH-1:0] move,
  output logic             move_valid,
  input  logic             move_ready,
  output logic             move_error
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0] VEC_RST = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_INIT, S_ARMED, S_OFFER, S_RELEASE} state_t;

  logic [WIDTH:0]   sync1_q, sync1_d;
  logic [WIDTH:0]   sync2_q, sync2_d;
  logic [WIDTH:0]   cand_q, cand_d;
  logic [WIDTH:0]   stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             committed_q, committed_d;
  logic             start_prev_q, start_prev_d;
  logic             start_pulse_q, start_pulse_d;
  logic [WIDTH-1:0] move_q, move_d;
  logic             move_error_q, move_error_d;
  state_t           state_q, state_d;
  logic             commit;
  logic             one_hot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= VEC_RST;
      sync2_q       <= VEC_RST;
      cand_q        <= VEC_RST;
      stable_q      <= VEC_RST;
      cnt_q         <= '0;
      committed_q   <= 1'b0;
      start_prev_q  <= 1'b1;
      start_pulse_q <= 1'b0;
      move_q        <= '0;
      move_error_q  <= 1'b0;
      state_q       <= S_INIT;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      committed_q   <= committed_d;
      start_prev_q  <= start_prev_d;
      start_pulse_q <= start_pulse_d;
      move_q        <= move_d;
      move_error_q  <= move_error_d;
      state_q       <= state_d;
    end
  end

  // One counter covers the whole vector: any bit changing restarts the window.
  always_comb begin
    sync1_d = {start_raw, switch_raw};
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    commit        = (cnt_q == CNT_MAX);
    stable_d      = commit ? cand_q : stable_q;
    committed_d   = committed_q | commit;
    start_prev_d  = stable_q[WIDTH];
    start_pulse_d = start_prev_q & ~stable_q[WIDTH];
  end

  assign switch_out = stable_q[WIDTH-1:0];
  assign parity     = ^switch_out;
  assign one_hot    = ((switch_out & (switch_out - WIDTH'(1))) == '0);

  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    move_error_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (committed_q) state_d = (switch_out == '0) ? S_ARMED : S_RELEASE;
      end
      S_ARMED: begin
        if (switch_out != '0) begin
          if (one_hot) begin
            move_d  = switch_out;
            state_d = S_OFFER;
          end else begin
            move_error_d = 1'b1;
            state_d      = S_RELEASE;
          end
        end
      end
      S_OFFER: begin
        if (move_ready) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (switch_out == '0) state_d = S_ARMED;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign start_pulse = start_pulse_q;
  assign move        = move_q;
  assign move_valid  = (state_q == S_OFFER);
  assign move_error  = move_error_q;

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with DEBOUNCE_CYCLES=4: debounce latency,
// bounce rejection, handshake hold, multi-press error, start pulse and reset abort.
module tb_player_input;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] switch_raw;
  logic         start_raw;
  logic [W-1:0] switch_out;
  logic         parity;
  logic         start_pulse;
  logic [W-1:0] move;
  logic         move_valid;
  logic         move_ready;
  logic         move_error;

  int checks   = 0;
  int failures = 0;

  player_input #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .switch_raw  (switch_raw),
    .start_raw   (start_raw),
    .switch_out  (switch_out),
    .parity      (parity),
    .start_pulse (start_pulse),
    .move        (move),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_error  (move_error)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    switch_raw = '0;
    start_raw  = 1'b1;
    move_ready = 1'b0;
    #22;
    check("rst_switch_out", 32'(switch_out), 32'h0);
    check("rst_parity", 32'(parity), 32'h0);
    check("rst_start_pulse", 32'(start_pulse), 32'h0);
    check("rst_move", 32'(move), 32'h0);
    check("rst_move_valid", 32'(move_valid), 32'h0);
    check("rst_move_error", 32'(move_error), 32'h0);
    reset = 1'b1;
    tick(10);

    // single press: commit at edge 7, offer at edge 8
    switch_raw = 10'h200;
    tick(6);
    check("t1_pre_commit", 32'(switch_out), 32'h0);
    tick(1);
    check("t1_switch_out", 32'(switch_out), 32'h200);
    check("t1_parity", 32'(parity), 32'h1);
    check("t1_valid_not_yet", 32'(move_valid), 32'h0);
    tick(1);
    check("t1_valid", 32'(move_valid), 32'h1);
    check("t1_move", 32'(move), 32'h200);
    check("t1_no_error", 32'(move_error), 32'h0);
    move_ready = 1'b1;
    tick(1);
    check("t1_transfer", 32'(move_valid), 32'h0);
    move_ready = 1'b0;
    switch_raw = '0;
    tick(10);
    check("t1_released", 32'(switch_out), 32'h0);

    // bouncing switch 3
    for (int i = 0; i < 10; i++) begin
      switch_raw[3] = ~switch_raw[3];
      tick(1);
      check("t2_bounce_valid", 32'(move_valid), 32'h0);
      tick(1);
      check("t2_bounce_out", 32'(switch_out), 32'h0);
    end
    switch_raw[3] = 1'b1;
    tick(6);
    check("t2_pre_commit", 32'(switch_out), 32'h0);
    tick(1);
    check("t2_switch_out", 32'(switch_out), 32'h008);
    tick(1);
    check("t2_valid", 32'(move_valid), 32'h1);
    check("t2_move", 32'(move), 32'h008);
    move_ready = 1'b1;
    tick(1);
    check("t2_transfer", 32'(move_valid), 32'h0);
    move_ready = 1'b0;
    switch_raw = '0;
    tick(10);

    // offer held while switches change underneath
    switch_raw = 10'h001;
    tick(8);
    check("t3_valid", 32'(move_valid), 32'h1);
    check("t3_move", 32'(move), 32'h001);
    switch_raw = 10'h003;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_hold_valid", 32'(move_valid), 32'h1);
      check("t3_hold_move", 32'(move), 32'h001);
    end
    check("t3_switch_out", 32'(switch_out), 32'h003);
    check("t3_parity", 32'(parity), 32'h0);
    move_ready = 1'b1;
    tick(1);
    check("t3_transfer", 32'(move_valid), 32'h0);
    move_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_no_reoffer", 32'(move_valid), 32'h0);
    end
    switch_raw = '0;
    tick(10);

    // two switches at once -> error pulse
    switch_raw = 10'h005;
    tick(7);
    check("t4_switch_out", 32'(switch_out), 32'h005);
    check("t4_no_err_yet", 32'(move_error), 32'h0);
    tick(1);
    check("t4_error", 32'(move_error), 32'h1);
    check("t4_no_valid", 32'(move_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t4_err_single", 32'(move_error), 32'h0);
      check("t4_valid_low", 32'(move_valid), 32'h0);
    end
    switch_raw = '0;
    tick(10);
    switch_raw = 10'h010;
    tick(7);
    check("t4b_parity", 32'(parity), 32'h1);
    tick(1);
    check("t4b_valid", 32'(move_valid), 32'h1);
    check("t4b_move", 32'(move), 32'h010);
    check("t4b_no_error", 32'(move_error), 32'h0);
    move_ready = 1'b1;
    tick(1);
    check("t4b_transfer", 32'(move_valid), 32'h0);
    move_ready = 1'b0;
    switch_raw = '0;
    tick(10);

    // start button: one pulse on press, none on release or glitch
    start_raw = 1'b0;
    tick(7);
    check("t5_no_pulse_yet", 32'(start_pulse), 32'h0);
    tick(1);
    check("t5_pulse", 32'(start_pulse), 32'h1);
    tick(1);
    check("t5_pulse_single", 32'(start_pulse), 32'h0);
    tick(1);
    start_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t5_release_nopulse", 32'(start_pulse), 32'h0);
    end
    start_raw = 1'b0;
    tick(2);
    start_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t5_glitch_nopulse", 32'(start_pulse), 32'h0);
    end

    // reset during an offer, switch held through reset
    switch_raw = 10'h040;
    tick(8);
    check("t6_valid", 32'(move_valid), 32'h1);
    reset = 1'b0;
    #2;
    check("t6_async_valid", 32'(move_valid), 32'h0);
    check("t6_async_move", 32'(move), 32'h0);
    #2;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t6_held_no_move", 32'(move_valid), 32'h0);
    end
    check("t6_switch_out", 32'(switch_out), 32'h040);
    switch_raw = '0;
    tick(10);
    check("t6_released", 32'(move_valid), 32'h0);
    switch_raw = 10'h040;
    tick(7);
    check("t6_pre_valid", 32'(move_valid), 32'h0);
    tick(1);
    check("t6_repress_valid", 32'(move_valid), 32'h1);
    check("t6_repress_move", 32'(move), 32'h040);
    move_ready = 1'b1;
    tick(1);
    check("t6_transfer", 32'(move_valid), 32'h0);
    move_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
